imem_boot_loader: RTL and testbench

- Boot-time controller for the core's instruction memory.
- Accepts a byte stream over a valid/ready handshake, packs it little-endian into 32-bit instruction words, and writes them sequentially from word 0.
- Holds the core in reset (active-low core reset) until a complete program with a matching checksum is loaded.
- Sits between the external loader link and the instruction memory write port.

---
 rtl/imem_boot_loader.sv | 126 ++++++++++++
 tb/tb_imem_boot_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream, packs it
// little-endian into 32-bit words for instruction memory, and releases core reset on success.
module imem_boot_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_LOAD, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

  state_t              r_state, w_next;
  logic [15:0]         r_len;
  logic [1:0]          r_lane;
  logic [7:0]          r_csum;
  logic [31:0]         r_word;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [31:0]         r_wdata;
  logic [15:0]         r_wcount;

  logic                w_busy;
  logic                w_acc;
  logic [15:0]         w_n;
  logic                w_last;
  logic [31:0]         w_word;

  assign w_busy = (r_state == S_HDR0) || (r_state == S_HDR1) ||
                  (r_state == S_LOAD) || (r_state == S_CSUM);
  assign w_acc  = rx_valid & w_busy;
  assign w_n    = {rx_data, r_len[7:0]};
  assign w_last = (r_wcount + 16'd1) == r_len;
  // Byte 0 ends up in bits [7:0] after four right-shifting accepts.
  assign w_word = {rx_data, r_word[31:8]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_HDR0;
      S_HDR0: if (w_acc) w_next = S_HDR1;
      S_HDR1: begin
        if (w_acc) begin
          if ({1'b0, w_n} > CAP)  w_next = S_ERROR;
          else if (w_n == 16'd0)  w_next = S_CSUM;
          else                    w_next = S_LOAD;
        end
      end
      S_LOAD: if (w_acc && r_lane == 2'd3 && w_last) w_next = S_CSUM;
      S_CSUM: if (w_acc) w_next = (rx_data == r_csum) ? S_DONE : S_ERROR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len    <= '0;
      r_lane   <= '0;
      r_csum   <= '0;
      r_word   <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_wcount <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_len    <= '0;
            r_lane   <= '0;
            r_csum   <= '0;
            r_wcount <= '0;
          end
        end
        S_HDR0: if (w_acc) r_len[7:0]  <= rx_data;
        S_HDR1: if (w_acc) r_len[15:8] <= rx_data;
        S_LOAD: begin
          if (w_acc) begin
            r_word <= w_word;
            r_csum <= r_csum ^ rx_data;
            r_lane <= r_lane + 2'd1;
            if (r_lane == 2'd3) begin
              r_we     <= 1'b1;
              r_waddr  <= r_wcount[ADDR_W-1:0];
              r_wdata  <= w_word;
              r_wcount <= r_wcount + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_ready   = w_busy;
  assign busy       = w_busy;
  assign done       = (r_state == S_DONE);
  assign error      = (r_state == S_ERROR);
  assign cpu_rst_n  = (r_state == S_DONE);
  assign imem_we    = r_we;
  assign imem_waddr = r_waddr;
  assign imem_wdata = r_wdata;
  assign word_count = r_wcount;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: hand-computed streams, write log, async reset.
module tb_imem_boot_loader;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst_n, busy, done, error;
  logic [15:0]   word_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [AW-1:0] wa [8];
  logic [31:0]   wd [8];
  int unsigned   wn = 0;

  imem_boot_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      if (wn < 8) begin
        wa[wn] = imem_waddr;
        wd[wn] = imem_wdata;
      end
      wn = wn + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_two_words(input string tag);
    chk({tag, "_wn"},  wn, 32'd2);
    chk({tag, "_a0"},  32'(wa[0]), 32'd0);
    chk({tag, "_d0"},  wd[0], 32'h0022_8293);
    chk({tag, "_a1"},  32'(wa[1]), 32'd1);
    chk({tag, "_d1"},  wd[1], 32'h0062_E233);
  endtask

  logic [7:0] s1 [11];

  initial begin
    s1 = '{8'h02, 8'h00, 8'h93, 8'h82, 8'h22, 8'h00, 8'h33, 8'hE2, 8'h62, 8'h00, 8'h80};

    // reset state
    @(negedge clk);
    chk("rst_ready", 32'(rx_ready), 0);
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_cpu", 32'(cpu_rst_n), 0);
    chk("rst_flags", {29'd0, busy, done, error}, 0);
    chk("rst_wc", 32'(word_count), 0);
    rst = 1'b0;
    idle(2);

    // 1: two-word program, good checksum
    pulse_start();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_ready", 32'(rx_ready), 1);
    wn = 0;
    for (int i = 0; i < 11; i++) send_byte(s1[i]);
    idle(2);
    check_two_words("t1");
    chk("t1_done", {29'd0, busy, done, error}, 32'b010);
    chk("t1_cpu", 32'(cpu_rst_n), 1);
    chk("t1_wc", 32'(word_count), 2);
    chk("t1_ready_off", 32'(rx_ready), 0);
    chk("t1_hold_d", imem_wdata, 32'h0062_E233);
    chk("t1_hold_a", 32'(imem_waddr), 1);

    // 2: bad checksum
    pulse_start();
    chk("t2_cpu_drop", 32'(cpu_rst_n), 0);
    chk("t2_done_clr", 32'(done), 0);
    wn = 0;
    for (int i = 0; i < 10; i++) send_byte(s1[i]);
    send_byte(8'h81);
    idle(2);
    check_two_words("t2");
    chk("t2_err", {29'd0, busy, done, error}, 32'b001);
    chk("t2_cpu", 32'(cpu_rst_n), 0);
    chk("t2_wc", 32'(word_count), 2);

    // 3: oversize header N=1025
    pulse_start();
    chk("t3_err_clr", 32'(error), 0);
    wn = 0;
    send_byte(8'h01);
    send_byte(8'h04);
    chk("t3_err", {29'd0, busy, done, error}, 32'b001);
    chk("t3_ready", 32'(rx_ready), 0);
    idle(2);
    chk("t3_wn", wn, 0);
    chk("t3_wc", 32'(word_count), 0);

    // 4: empty program, then one-word program
    pulse_start();
    wn = 0;
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(2);
    chk("t4a_done", {29'd0, busy, done, error}, 32'b010);
    chk("t4a_wn", wn, 0);
    chk("t4a_wc", 32'(word_count), 0);
    pulse_start();
    wn = 0;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h13);
    idle(2);
    chk("t4b_wn", wn, 1);
    chk("t4b_a0", 32'(wa[0]), 0);
    chk("t4b_d0", wd[0], 32'h0000_0013);
    chk("t4b_done", {29'd0, busy, done, error}, 32'b010);
    chk("t4b_wc", 32'(word_count), 1);

    // 5: gaps in the stream and a start pulse mid-load
    pulse_start();
    wn = 0;
    send_byte(s1[0]); send_byte(s1[1]);
    for (int i = 2; i < 10; i++) begin
      idle((i * 3) % 4);
      if (i == 5) begin
        pulse_start();
        chk("t5_busy_mid", 32'(busy), 1);
      end
      send_byte(s1[i]);
    end
    idle(3);
    send_byte(s1[10]);
    idle(2);
    check_two_words("t5");
    chk("t5_done", {29'd0, busy, done, error}, 32'b010);
    chk("t5_wc", 32'(word_count), 2);

    // 6: async reset after five payload bytes, then a clean reload
    pulse_start();
    wn = 0;
    for (int i = 0; i < 7; i++) send_byte(s1[i]);
    #2 rst = 1'b1;
    #1;
    chk("t6_ready", 32'(rx_ready), 0);
    chk("t6_we", 32'(imem_we), 0);
    chk("t6_addr", 32'(imem_waddr), 0);
    chk("t6_data", imem_wdata, 0);
    chk("t6_flags", {28'd0, cpu_rst_n, busy, done, error}, 0);
    chk("t6_wc", 32'(word_count), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    pulse_start();
    wn = 0;
    for (int i = 0; i < 11; i++) send_byte(s1[i]);
    idle(2);
    check_two_words("t6");
    chk("t6_done", {29'd0, busy, done, error}, 32'b010);
    chk("t6_cpu", 32'(cpu_rst_n), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
